// File: rtl/dcache_line_mover_pkg.sv
// Shared D-cache miss-engine definitions: widths and FSM state encoding.
// Imported by dcache_line_mover.
package dcache_defs;

    localparam int INDEX_W  = 7;
    localparam int LINE_W   = 256;
    localparam int BEAT_W   = 32;
    localparam int BEATS    = LINE_W / BEAT_W;
    localparam int CNT_W    = 3;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_WB_RD   = 4'd1;
    localparam logic [3:0] ST_WB_REQ  = 4'd2;
    localparam logic [3:0] ST_WB_DATA = 4'd3;
    localparam logic [3:0] ST_WB_RESP = 4'd4;
    localparam logic [3:0] ST_RF_REQ  = 4'd5;
    localparam logic [3:0] ST_RF_DATA = 4'd6;
    localparam logic [3:0] ST_RF_WR   = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE    = ST_IDLE,
        S_WB_RD   = ST_WB_RD,
        S_WB_REQ  = ST_WB_REQ,
        S_WB_DATA = ST_WB_DATA,
        S_WB_RESP = ST_WB_RESP,
        S_RF_REQ  = ST_RF_REQ,
        S_RF_DATA = ST_RF_DATA,
        S_RF_WR   = ST_RF_WR,
        S_DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/dcache_line_mover.sv
// D-cache miss engine on BRAM port B: victim write-back and line refill.
// Optional early restart of the requested word: DCACHE_EARLY_RESTART_EN.
module dcache_line_mover
    import dcache_defs::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_dirty,
    input  logic [INDEX_W-1:0] req_index,
    input  logic [ADDR_W-1:0]  req_wb_addr,
    input  logic [ADDR_W-1:0]  req_rf_addr,
    input  logic [CNT_W-1:0]   req_word,
    output logic               busy,
    output logic               done,
    output logic [LINE_W-1:0]  line_out,
    output logic               early_valid,
    output logic [BEAT_W-1:0]  early_data,
    output logic [INDEX_W-1:0] bram_addr,
    output logic               bram_we,
    output logic [LINE_W-1:0]  bram_din,
    input  logic [LINE_W-1:0]  bram_dout,
    output logic               mrd_req,
    output logic [ADDR_W-1:0]  mrd_addr,
    input  logic               mrd_ack,
    input  logic               mrd_valid,
    input  logic [BEAT_W-1:0]  mrd_data,
    input  logic               mrd_last,
    output logic               mwr_req,
    output logic [ADDR_W-1:0]  mwr_addr,
    input  logic               mwr_ack,
    output logic               mwr_valid,
    output logic [BEAT_W-1:0]  mwr_data,
    output logic               mwr_last,
    input  logic               mwr_ready,
    input  logic               mwr_resp
);

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [LINE_W-1:0]         buf_q;
    logic [LINE_W-1:0]         line_q;
    logic [INDEX_W-1:0]        idx_q;
    logic [ADDR_W-1:OFFSET_W]  wb_q;
    logic [ADDR_W-1:OFFSET_W]  rf_q;
    logic                      ready_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      we_q;
    logic                      mrd_req_q;
    logic                      mwr_req_q;
    logic                      mwr_valid_q;
    logic                      last_beat;
    logic [2*OFFSET_W-1:0]     unused_lo;

    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    assign unused_lo = {req_wb_addr[OFFSET_W-1:0], req_rf_addr[OFFSET_W-1:0]};

    // Address goes out in the accept cycle so the victim is on doutb during WB_RD.
    assign bram_addr = (state == S_IDLE && req_valid) ? req_index : idx_q;
    assign bram_we   = we_q;
    assign bram_din  = buf_q;
    assign line_out  = line_q;
    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mrd_req   = mrd_req_q;
    assign mrd_addr  = {rf_q, {OFFSET_W{1'b0}}};
    assign mwr_req   = mwr_req_q;
    assign mwr_addr  = {wb_q, {OFFSET_W{1'b0}}};
    assign mwr_valid = mwr_valid_q;
    assign mwr_data  = mwr_valid_q ? buf_q[int'(cnt) * BEAT_W +: BEAT_W] : '0;
    assign mwr_last  = mwr_valid_q && last_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            buf_q       <= '0;
            line_q      <= '0;
            idx_q       <= '0;
            wb_q        <= '0;
            rf_q        <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            mrd_req_q   <= 1'b0;
            mwr_req_q   <= 1'b0;
            mwr_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        idx_q   <= req_index;
                        wb_q    <= req_wb_addr[ADDR_W-1:OFFSET_W];
                        rf_q    <= req_rf_addr[ADDR_W-1:OFFSET_W];
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (req_dirty) begin
                            state <= S_WB_RD;
                        end else begin
                            state     <= S_RF_REQ;
                            mrd_req_q <= 1'b1;
                        end
                    end
                end
                S_WB_RD: begin
                    buf_q     <= bram_dout;
                    mwr_req_q <= 1'b1;
                    state     <= S_WB_REQ;
                end
                S_WB_REQ: begin
                    if (mwr_ack) begin
                        mwr_req_q   <= 1'b0;
                        mwr_valid_q <= 1'b1;
                        cnt         <= '0;
                        state       <= S_WB_DATA;
                    end
                end
                S_WB_DATA: begin
                    if (mwr_ready) begin
                        if (last_beat) begin
                            mwr_valid_q <= 1'b0;
                            cnt         <= '0;
                            state       <= S_WB_RESP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_WB_RESP: begin
                    if (mwr_resp) begin
                        mrd_req_q <= 1'b1;
                        state     <= S_RF_REQ;
                    end
                end
                S_RF_REQ: begin
                    // Cleared buffer leaves missing words 0 on a short burst.
                    if (mrd_ack) begin
                        mrd_req_q <= 1'b0;
                        cnt       <= '0;
                        buf_q     <= '0;
                        state     <= S_RF_DATA;
                    end
                end
                S_RF_DATA: begin
                    if (mrd_valid) begin
                        buf_q[int'(cnt) * BEAT_W +: BEAT_W] <= mrd_data;
                        if (mrd_last || last_beat) begin
                            we_q  <= 1'b1;
                            state <= S_RF_WR;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_RF_WR: begin
                    line_q <= buf_q;
                    done_q <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DCACHE_EARLY_RESTART_EN
    logic [CNT_W-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (state == S_IDLE && req_valid) begin
            word_q <= req_word;
        end
    end

    assign early_valid = (state == S_RF_DATA) && mrd_valid && (cnt == word_q);
    assign early_data  = early_valid ? mrd_data : '0;
`else
    logic [CNT_W-1:0] unused_word;

    assign unused_word = req_word;
    assign early_valid = 1'b0;
    assign early_data  = '0;
`endif

endmodule

// File: tb/tb_dcache_line_mover.sv
// Scoreboard bench for dcache_line_mover with BRAM and memory-bridge models.
// Early-restart expectations follow DCACHE_EARLY_RESTART_EN.
module tb_dcache_line_mover;

    typedef struct packed { logic [255:0] line; logic [3:0] n; } rd_t;
    typedef struct packed { logic [6:0] idx; logic [255:0] line; } we_t;
    typedef struct packed { logic [255:0] line; logic [7:0] lat; } dn_t;
    typedef struct packed { logic [7:0] cnt; logic [31:0] data; } ea_t;

    logic         clk = 0;
    logic         rst_n;
    logic         req_valid, req_ready, req_dirty;
    logic [6:0]   req_index;
    logic [31:0]  req_wb_addr, req_rf_addr;
    logic [2:0]   req_word;
    logic         busy, done;
    logic [255:0] line_out;
    logic         early_valid;
    logic [31:0]  early_data;
    logic [6:0]   bram_addr;
    logic         bram_we;
    logic [255:0] bram_din, bram_dout;
    logic         mrd_req, mrd_ack, mrd_valid, mrd_last;
    logic [31:0]  mrd_addr, mrd_data;
    logic         mwr_req, mwr_ack, mwr_valid, mwr_last, mwr_ready, mwr_resp;
    logic [31:0]  mwr_addr, mwr_data;

    int checks = 0;
    int errors = 0;

    logic [255:0] mem [128];
    logic [255:0] last_line;
    int cyc = 0, acc_cyc = 0, done_cnt = 0, early_seen = 0;
    int rs = 0, ri = 0, ws = 0, wi = 0, rw = 0;
    int stall_beat = -1, stall_left = 0;
    bit wb_open = 0;
    rd_t cur;

    rd_t         rd_q[$];
    we_t         bq[$];
    dn_t         dq[$];
    ea_t         eq[$];
    logic [31:0] wbeat_q[$], ra_q[$], wa_q[$];

    dcache_line_mover dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dirty(req_dirty), .req_index(req_index),
        .req_wb_addr(req_wb_addr), .req_rf_addr(req_rf_addr),
        .req_word(req_word), .busy(busy), .done(done),
        .line_out(line_out), .early_valid(early_valid),
        .early_data(early_data), .bram_addr(bram_addr),
        .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
        .mrd_req(mrd_req), .mrd_addr(mrd_addr), .mrd_ack(mrd_ack),
        .mrd_valid(mrd_valid), .mrd_data(mrd_data), .mrd_last(mrd_last),
        .mwr_req(mwr_req), .mwr_addr(mwr_addr), .mwr_ack(mwr_ack),
        .mwr_valid(mwr_valid), .mwr_data(mwr_data), .mwr_last(mwr_last),
        .mwr_ready(mwr_ready), .mwr_resp(mwr_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Memory-bridge models and output monitors, all on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            rs = 0; ws = 0; wb_open = 0; early_seen = 0; last_line = '0;
            mrd_ack = 0; mrd_valid = 0; mrd_last = 0; mrd_data = 0;
            mwr_ack = 0; mwr_ready = 0; mwr_resp = 0;
        end else begin
            mrd_ack = 0; mrd_valid = 0; mrd_last = 0; mrd_data = 0;
            if (rs == 0) begin
                if (mrd_req) begin
                    mrd_ack = 1;
                    chk("rf_after_resp", wb_open, 0);
                    if (rd_q.size() == 0) chk("rd_unexp", 1, 0);
                    else begin
                        chk("mrd_addr", mrd_addr, ra_q.pop_front());
                        cur = rd_q.pop_front(); ri = 0; rs = 1;
                    end
                end
            end else begin
                mrd_valid = 1;
                mrd_data = cur.line[ri*32 +: 32];
                mrd_last = (ri == int'(cur.n) - 1);
                ri++;
                if (ri == int'(cur.n)) rs = 0;
            end

            mwr_ack = 0; mwr_resp = 0;
            case (ws)
                0: if (mwr_req) begin
                    mwr_ack = 1; mwr_ready = 0;
                    chk("mwr_addr", mwr_addr, wa_q.pop_front());
                    wb_open = 1; wi = 0; ws = 1;
                end
                1: begin
                    if (wi == stall_beat && stall_left > 0) begin
                        mwr_ready = 0; stall_left--;
                    end else mwr_ready = 1;
                    if (mwr_valid) begin
                        if (mwr_ready) begin
                            chk("wb_data", mwr_data, wbeat_q.pop_front());
                            chk("wb_last", mwr_last, wi == 7);
                            wi++;
                            if (wi == 8) begin ws = 2; rw = 2; end
                        end else begin
                            chk("wb_hold", mwr_data, wbeat_q[0]);
                        end
                    end
                end
                default: begin
                    mwr_ready = 0;
                    if (rw == 0) begin mwr_resp = 1; wb_open = 0; ws = 0; end
                    else rw--;
                end
            endcase

            if (req_valid && req_ready) acc_cyc = cyc;
            if (bram_we) begin
                if (bq.size() == 0) chk("we_unexp", 1, 0);
                else begin
                    we_t e;
                    e = bq.pop_front();
                    chk("we_idx", bram_addr, e.idx);
                    chk("we_din", bram_din, e.line);
                end
                chk("line_hold", line_out, last_line);
            end
            if (early_valid) begin
                early_seen++;
                if (eq.size() == 0) chk("early_unexp", 1, 0);
                else chk("early_data", early_data, eq[0].data);
            end
            if (done) begin
                if (dq.size() == 0 || eq.size() == 0) chk("done_unexp", 1, 0);
                else begin
                    dn_t d;
                    ea_t a;
                    d = dq.pop_front();
                    a = eq.pop_front();
                    chk("line_out", line_out, d.line);
                    if (d.lat != 0) chk("latency", cyc - acc_cyc, d.lat);
                    chk("early_cnt", early_seen, a.cnt);
                    last_line = d.line;
                end
                chk("rdy_low", req_ready, 0);
                early_seen = 0;
                done_cnt++;
            end
        end
    end

    task automatic issue(input logic [6:0] idx, input logic dirty,
                         input logic [31:0] wb, input logic [31:0] rf,
                         input logic [2:0] word, input logic [255:0] victim,
                         input logic [255:0] line, input int n, input bit abort);
        logic [255:0] m;
        ea_t a;
        m = '0;
        for (int i = 0; i < n; i++) m[i*32 +: 32] = line[i*32 +: 32];
        if (dirty) begin
            for (int i = 0; i < 8; i++) wbeat_q.push_back(victim[i*32 +: 32]);
            wa_q.push_back({wb[31:5], 5'b0});
        end
        ra_q.push_back({rf[31:5], 5'b0});
        rd_q.push_back({line, 4'(n)});
        if (!abort) begin
            bq.push_back({idx, m});
            dq.push_back({m, (dirty || n != 8) ? 8'd0 : 8'd11});
            a.data = line[int'(word)*32 +: 32];
`ifdef DCACHE_EARLY_RESTART_EN
            a.cnt = (int'(word) < n) ? 8'd1 : 8'd0;
`else
            a.cnt = 8'd0;
`endif
            eq.push_back(a);
        end
        req_index = idx; req_dirty = dirty; req_wb_addr = wb;
        req_rf_addr = rf; req_word = word; req_valid = 1;
    endtask

    task automatic send(input bit hold);
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin got = 1; break; end
        end
        if (!got) chk("accept_timeout", 1, 0);
        @(posedge clk); #1;
        if (!hold) req_valid = 0;
    endtask

    task automatic wait_done(input int target);
        int i = 0;
        while (done_cnt < target && i < 400) begin
            @(posedge clk); i++;
        end
        if (done_cnt < target) chk("done_timeout", done_cnt, target);
        #1;
    endtask

    function automatic logic [255:0] mkline(input logic [31:0] base,
                                            input logic [31:0] step);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + step * i;
        return l;
    endfunction

    initial begin
        logic [255:0] v9, l2, l3, l4, l5, l6, l7;
        bit hit4;
        rst_n = 0; req_valid = 0; req_dirty = 0; req_index = 0;
        req_wb_addr = 0; req_rf_addr = 0; req_word = 0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        v9 = mkline(32'hA0, 32'h1);
        mem[9] = v9;
        l2 = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
        l3 = mkline(32'h3000_0001, 32'h100);
        l4 = mkline(32'h4400_0000, 32'h3);
        l5 = mkline(32'h5500_0005, 32'h11);
        l6 = mkline(32'h6600_0000, 32'h7);
        l7 = mkline(32'h7700_0000, 32'h9);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", bram_we, 0);
        chk("rst_mrd_req", mrd_req, 0);
        chk("rst_mwr_req", mwr_req, 0);
        chk("rst_mwr_valid", mwr_valid, 0);
        chk("rst_early", early_valid, 0);
        chk("rst_line", line_out, 0);
        chk("rst_addr", bram_addr, 0);
        rst_n = 1;
        @(posedge clk); #1;

        issue(7'd5, 0, 0, 32'h1000_0040, 3'd6, '0,
              mkline(32'h11, 32'h11), 8, 0);
        send(0);
        wait_done(1);

        stall_beat = 2; stall_left = 3;
        issue(7'd9, 1, 32'h2000_0120, 32'h3000_0060, 3'd3, v9, l2, 8, 0);
        send(0);
        wait_done(2);
        stall_beat = -1;

        issue(7'd12, 0, 0, 32'h4000_00bf, 3'd6, '0, l3, 5, 0);
        send(0);
        wait_done(3);

        issue(7'd20, 0, 0, 32'h5000_0000, 3'd0, '0, l4, 8, 1);
        send(0);
        hit4 = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rs == 1 && ri == 5) begin hit4 = 1; break; end
        end
        chk("beat4_reached", hit4, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_ready", req_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_we", bram_we, 0);
        chk("arst_mrd_req", mrd_req, 0);
        chk("arst_line", line_out, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        chk("no_write_20", mem[20], 0);

        issue(7'd20, 0, 0, 32'h5000_0040, 3'd2, '0, l5, 8, 0);
        send(0);
        wait_done(4);

        issue(7'd30, 0, 0, 32'h6000_0080, 3'd0, '0, l6, 8, 0);
        send(1);
        issue(7'd31, 0, 0, 32'h6000_00c0, 3'd7, '0, l7, 8, 0);
        send(0);
        wait_done(6);

        repeat (4) @(posedge clk);
        chk("q_drained", bq.size() + dq.size() + wbeat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
